// File: rtl/smartlot_audio_pkg.sv
// Shared types for the chime tone generator: note descriptor, FSM states and the
// fixed chime pattern table (half-period and duration counted in samples).
package smartlot_audio_pkg;

  typedef struct packed {
    logic [7:0]  half_period;
    logic [15:0] duration;
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TONE   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam note_t NOTE_END = '{half_period: 8'd0, duration: 16'd0};

  // half_period == 0 terminates a pattern; row index is the pattern select
  localparam note_t CHIME_TABLE [4][4] = '{
    '{'{8'd24, 16'd9600},  NOTE_END,              NOTE_END,             NOTE_END},
    '{'{8'd27, 16'd12000}, '{8'd36, 16'd12000},   NOTE_END,             NOTE_END},
    '{'{8'd12, 16'd4800},  '{8'd12, 16'd4800},    '{8'd12, 16'd4800},   NOTE_END},
    '{'{8'd60, 16'd24000}, NOTE_END,              NOTE_END,             NOTE_END}
  };

endpackage

// File: rtl/chime_note_osc.sv
// Square-wave oscillator for one note: half-period counter and polarity bit,
// stepped once per issued sample; restart re-arms it at polarity +.
module chime_note_osc (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       advance_i,
  input  logic       restart_i,
  input  logic [7:0] half_period_i,
  output logic       polarity_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       pol_q, pol_d;

  always_comb begin
    cnt_d = cnt_q;
    pol_d = pol_q;
    if (restart_i) begin
      cnt_d = 8'd0;
      pol_d = 1'b1;
    end else if (advance_i) begin
      if (cnt_q == half_period_i - 8'd1) begin
        cnt_d = 8'd0;
        pol_d = ~pol_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= 8'd0;
      pol_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      pol_q <= pol_d;
    end
  end

  assign polarity_o = pol_q;

endmodule

// File: rtl/chime_tone_generator.sv
// Plays fixed chime patterns as square-wave PCM into the audio-out FIFO, one stereo
// sample per strobe, paced by audio_out_allowed; all timing is counted in samples.
import smartlot_audio_pkg::*;

module chime_tone_generator #(
  parameter int          SAMPLE_W    = 32,
  parameter logic [31:0] AMPLITUDE   = 32'h1000_0000,
  parameter int          GAP_SAMPLES = 2400
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          pattern,
  input  logic [1:0]          volume,
  input  logic                stop,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic                busy,
  output logic                done
);

  state_t state_q, state_d;

  logic [1:0]          pat_q, vol_q, idx_q;
  logic [15:0]         dur_cnt_q, gap_cnt_q;
  logic                wr_q;
  logic [SAMPLE_W-1:0] smp_q;

  note_t               cur_note;
  logic [1:0]          idx_nxt;
  logic [7:0]          nxt_half_period;
  logic                start_acc, issue, dur_last, gap_last, last_note;
  logic                osc_restart, osc_advance, polarity;
  logic signed [31:0]  amp32;
  logic signed [SAMPLE_W-1:0] amp, smp_d;

  assign idx_nxt         = idx_q + 2'd1;
  assign cur_note        = CHIME_TABLE[pat_q][idx_q];
  assign nxt_half_period = CHIME_TABLE[pat_q][idx_nxt].half_period;
  assign last_note       = (idx_q == 2'd3) || (nxt_half_period == 8'd0);
  assign dur_last        = (dur_cnt_q == cur_note.duration - 16'd1);
  assign gap_last        = (gap_cnt_q == 16'(GAP_SAMPLES - 1));

  assign start_acc = (state_q == ST_IDLE) && start;
  // stop suppresses any new strobe; one already in the output register still goes out
  assign issue     = ((state_q == ST_TONE) || (state_q == ST_GAP)) && audio_out_allowed && !stop;

  assign osc_restart = start_acc || ((state_q == ST_GAP) && issue && gap_last);
  assign osc_advance = issue && (state_q == ST_TONE);

  chime_note_osc u_osc (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .advance_i     (osc_advance),
    .restart_i     (osc_restart),
    .half_period_i (cur_note.half_period),
    .polarity_o    (polarity)
  );

  assign amp32 = $signed(AMPLITUDE) >>> vol_q;
  assign amp   = SAMPLE_W'(amp32);
  assign smp_d = (state_q == ST_GAP) ? '0 : (polarity ? amp : -amp);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_TONE;
      ST_TONE: begin
        if (stop)                  state_d = ST_IDLE;
        else if (issue && dur_last) state_d = last_note ? ST_FINISH : ST_GAP;
      end
      ST_GAP: begin
        if (stop)                  state_d = ST_IDLE;
        else if (issue && gap_last) state_d = ST_TONE;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_FINISH);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pat_q     <= 2'd0;
      vol_q     <= 2'd0;
      idx_q     <= 2'd0;
      dur_cnt_q <= 16'd0;
      gap_cnt_q <= 16'd0;
      wr_q      <= 1'b0;
      smp_q     <= '0;
    end else begin
      wr_q <= issue;
      if (issue) smp_q <= smp_d;
      if (start_acc) begin
        pat_q     <= pattern;
        vol_q     <= volume;
        idx_q     <= 2'd0;
        dur_cnt_q <= 16'd0;
        gap_cnt_q <= 16'd0;
      end else if (issue && (state_q == ST_TONE)) begin
        dur_cnt_q <= dur_last ? 16'd0 : dur_cnt_q + 16'd1;
      end else if (issue && (state_q == ST_GAP)) begin
        gap_cnt_q <= gap_last ? 16'd0 : gap_cnt_q + 16'd1;
        if (gap_last) idx_q <= idx_nxt;
      end
    end
  end

  assign write_audio_out         = wr_q;
  assign left_channel_audio_out  = smp_q;
  assign right_channel_audio_out = smp_q;

endmodule

// File: tb/tb_chime_tone_generator.sv
// Directed bench for chime_tone_generator: plays each pattern and compares every
// strobed sample against a sample-indexed model of the chime table.
module tb_chime_tone_generator;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [1:0]  volume = 2'd0;
  logic        stop = 1'b0;
  logic        audio_out_allowed = 1'b0;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  localparam int RUN_LIMIT = 60000;

  chime_tone_generator dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .start                   (start),
    .pattern                 (pattern),
    .volume                  (volume),
    .stop                    (stop),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .busy                    (busy),
    .done                    (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected sample for strobe k of a pattern, from the hand-written note list
  function automatic logic [31:0] exp_sample(input int pat, input int vol, input int k);
    int n;
    int hps[3];
    int durs[3];
    logic [31:0] amp;
    int r;
    hps = '{0, 0, 0};
    durs = '{0, 0, 0};
    case (pat)
      0:       begin n = 1; hps[0] = 24; durs[0] = 9600; end
      1:       begin n = 2; hps[0] = 27; durs[0] = 12000; hps[1] = 36; durs[1] = 12000; end
      2:       begin n = 3; hps = '{12, 12, 12}; durs = '{4800, 4800, 4800}; end
      default: begin n = 1; hps[0] = 60; durs[0] = 24000; end
    endcase
    amp = 32'h1000_0000 >> vol;
    r = k;
    for (int i = 0; i < n; i++) begin
      if (r < durs[i]) return (((r / hps[i]) % 2) == 0) ? amp : -amp;
      r -= durs[i];
      if (i < n - 1) begin
        if (r < 2400) return 32'h0;
        r -= 2400;
      end
    end
    return 32'hDEAD_BEEF;
  endfunction

  task automatic run_pat(input string tag, input logic [1:0] pat, input logic [1:0] vol,
                         input bit two_of_three, input int stop_at, input int start_at,
                         output int n_str, output int n_err, output int n_zero,
                         output int n_done, output int n_after_stop, output logic busy_at_stop);
    int c;
    bit stop_sent, start_sent;
    logic [31:0] e;
    n_str = 0; n_err = 0; n_zero = 0; n_done = 0; n_after_stop = 0;
    busy_at_stop = 1'b1;
    stop_sent = 0; start_sent = 0;
    @(negedge CLOCK_50);
    pattern = pat; volume = vol; start = 1'b1; audio_out_allowed = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check_val({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    for (c = 0; c < RUN_LIMIT; c++) begin
      if (write_audio_out) begin
        e = exp_sample(int'(pat), int'(vol), n_str);
        if (left_channel_audio_out !== e || right_channel_audio_out !== e) n_err++;
        if (left_channel_audio_out == 32'h0) n_zero++;
        if (stop_sent) n_after_stop++;
        n_str++;
      end
      if (done) n_done++;
      if (stop) busy_at_stop = busy;
      if (!busy) break;
      stop = 1'b0;
      start = 1'b0;
      if (stop_at >= 0 && n_str == stop_at && !stop_sent) begin
        stop = 1'b1; stop_sent = 1;
      end
      if (start_at >= 0 && n_str == start_at && !start_sent) begin
        start = 1'b1; pattern = 2'd3; volume = 2'd3; start_sent = 1;
      end
      audio_out_allowed = two_of_three ? ((c % 3) != 2) : 1'b1;
      @(negedge CLOCK_50);
    end
    check_val({tag, "_terminated"}, 64'(c < RUN_LIMIT), 64'd1);
    stop = 1'b0; start = 1'b0;
    repeat (2) begin
      @(negedge CLOCK_50);
      if (write_audio_out) begin
        n_str++;
        if (stop_sent) n_after_stop++;
      end
      if (done) n_done++;
    end
    audio_out_allowed = 1'b0;
  endtask

  int ns, ne, nz, nd, nas;
  logic bs;

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check_val("rst_write", 64'(write_audio_out), 64'd0);
    check_val("rst_left", 64'(left_channel_audio_out), 64'd0);
    check_val("rst_right", 64'(right_channel_audio_out), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    reset = 1'b0;

    // p0 vol0, allowed held high, with a stray start at strobe 100 that must be ignored
    run_pat("p0", 2'd0, 2'd0, 1'b0, -1, 100, ns, ne, nz, nd, nas, bs);
    check_val("p0_strobes", 64'(ns), 64'd9600);
    check_val("p0_wave_errors", 64'(ne), 64'd0);
    check_val("p0_done_pulses", 64'(nd), 64'd1);

    // p1 with allowed low one cycle in three: same sample-space waveform
    run_pat("p1", 2'd1, 2'd0, 1'b1, -1, -1, ns, ne, nz, nd, nas, bs);
    check_val("p1_strobes", 64'(ns), 64'd26400);
    check_val("p1_wave_errors", 64'(ne), 64'd0);
    check_val("p1_zero_samples", 64'(nz), 64'd2400);
    check_val("p1_done_pulses", 64'(nd), 64'd1);

    // p2 vol3: +/-0x02000000 beeps separated by two gaps
    run_pat("p2", 2'd2, 2'd3, 1'b0, -1, -1, ns, ne, nz, nd, nas, bs);
    check_val("p2_strobes", 64'(ns), 64'd19200);
    check_val("p2_wave_errors", 64'(ne), 64'd0);
    check_val("p2_zero_samples", 64'(nz), 64'd4800);
    check_val("p2_done_pulses", 64'(nd), 64'd1);

    // p3 stopped after 5000 strobes
    run_pat("p3", 2'd3, 2'd0, 1'b0, 5000, -1, ns, ne, nz, nd, nas, bs);
    check_val("p3_after_stop_le1", 64'(nas <= 1), 64'd1);
    check_val("p3_busy_after_stop", 64'(bs), 64'd0);
    check_val("p3_done_pulses", 64'(nd), 64'd0);
    check_val("p3_wave_errors", 64'(ne), 64'd0);

    // reset in the middle of p1
    @(negedge CLOCK_50);
    pattern = 2'd1; volume = 2'd1; start = 1'b1; audio_out_allowed = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (300) @(negedge CLOCK_50);
    check_val("p1b_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check_val("mid_rst_write", 64'(write_audio_out), 64'd0);
    check_val("mid_rst_left", 64'(left_channel_audio_out), 64'd0);
    check_val("mid_rst_right", 64'(right_channel_audio_out), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    audio_out_allowed = 1'b0;

    // p0 afterwards starts cleanly at polarity +
    run_pat("p0b", 2'd0, 2'd0, 1'b0, 300, -1, ns, ne, nz, nd, nas, bs);
    check_val("p0b_wave_errors", 64'(ne), 64'd0);
    check_val("p0b_done_pulses", 64'(nd), 64'd0);
    check_val("p0b_strobes_ge300", 64'(ns >= 300), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
